// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Brief    : Seven-segment pattern type and the 32 glyph constants used by
//             the display decoder. Bit order is {A,B,C,D,E,F,G}, active-high.
//  Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    // One bit per segment, A in the MSB down to G in the LSB
    typedef logic [6:0] seg_t;

    // Hex digits, codes 0-15
    localparam seg_t SEG_0       = 7'b1111110;
    localparam seg_t SEG_1       = 7'b0110000;
    localparam seg_t SEG_2       = 7'b1101101;
    localparam seg_t SEG_3       = 7'b1111001;
    localparam seg_t SEG_4       = 7'b0110011;
    localparam seg_t SEG_5       = 7'b1011011;
    localparam seg_t SEG_6       = 7'b1011111;
    localparam seg_t SEG_7       = 7'b1110000;
    localparam seg_t SEG_8       = 7'b1111111;
    localparam seg_t SEG_9       = 7'b1111011;
    localparam seg_t SEG_A       = 7'b1110111;
    localparam seg_t SEG_B_LO    = 7'b0011111;
    localparam seg_t SEG_C       = 7'b1001110;
    localparam seg_t SEG_D_LO    = 7'b0111101;
    localparam seg_t SEG_E       = 7'b1001111;
    localparam seg_t SEG_F       = 7'b1000111;

    // Symbols, codes 16-31
    localparam seg_t SEG_DASH    = 7'b0000001;
    localparam seg_t SEG_H       = 7'b0110111;
    localparam seg_t SEG_L       = 7'b0001110;
    localparam seg_t SEG_P       = 7'b1100111;
    localparam seg_t SEG_U       = 7'b0111110;
    localparam seg_t SEG_N_LO    = 7'b0010101;
    localparam seg_t SEG_O_LO    = 7'b0011101;
    localparam seg_t SEG_R_LO    = 7'b0000101;
    localparam seg_t SEG_Y_LO    = 7'b0111011;
    localparam seg_t SEG_J       = 7'b0111000;
    localparam seg_t SEG_T_LO    = 7'b0001111;
    localparam seg_t SEG_U_LO    = 7'b0011100;
    localparam seg_t SEG_C_LO    = 7'b0001101;
    localparam seg_t SEG_UNDER   = 7'b0001000;
    localparam seg_t SEG_OVER    = 7'b1000000;
    localparam seg_t SEG_BLANK   = 7'b0000000;

endpackage : display_pkg
`default_nettype wire

// File: rtl/display_seg_lut.sv
`default_nettype none
// ============================================================================
//  Module   : display_seg_lut
//  Brief    : Purely combinational 5-bit code to active-high seven-segment
//             pattern lookup. Every one of the 32 codes maps to a glyph.
//  Revision : 1.0 - initial release
// ============================================================================
module display_seg_lut
    import display_pkg::*;
(
    input  logic [4:0] code,
    output seg_t       seg
);

    // Full table decode; the leading default keeps the block latch-free
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'd0:  seg = SEG_0;
            5'd1:  seg = SEG_1;
            5'd2:  seg = SEG_2;
            5'd3:  seg = SEG_3;
            5'd4:  seg = SEG_4;
            5'd5:  seg = SEG_5;
            5'd6:  seg = SEG_6;
            5'd7:  seg = SEG_7;
            5'd8:  seg = SEG_8;
            5'd9:  seg = SEG_9;
            5'd10: seg = SEG_A;
            5'd11: seg = SEG_B_LO;
            5'd12: seg = SEG_C;
            5'd13: seg = SEG_D_LO;
            5'd14: seg = SEG_E;
            5'd15: seg = SEG_F;
            5'd16: seg = SEG_DASH;
            5'd17: seg = SEG_H;
            5'd18: seg = SEG_L;
            5'd19: seg = SEG_P;
            5'd20: seg = SEG_U;
            5'd21: seg = SEG_N_LO;
            5'd22: seg = SEG_O_LO;
            5'd23: seg = SEG_R_LO;
            5'd24: seg = SEG_Y_LO;
            5'd25: seg = SEG_J;
            5'd26: seg = SEG_T_LO;
            5'd27: seg = SEG_U_LO;
            5'd28: seg = SEG_C_LO;
            5'd29: seg = SEG_UNDER;
            5'd30: seg = SEG_OVER;
            5'd31: seg = SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule : display_seg_lut
`default_nettype wire

// File: rtl/display.sv
`default_nettype none
// ============================================================================
//  Module   : display
//  Brief    : Registered seven-segment decoder. C1..C5 form a 5-bit code
//             (C1 = MSB); the glyph appears on A..G one clock later.
//  Config   : DISPLAY_ACTIVE_LOW_EN - when defined, segments are driven
//             active-low for common-anode parts (blank = 1111111).
//  Revision : 1.0 - initial release
// ============================================================================
module display
    import display_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic C1,
    input  logic C2,
    input  logic C3,
    input  logic C4,
    input  logic C5,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic E,
    output logic F,
    output logic G
);

    logic [4:0] code;
    seg_t       lut_seg;
    seg_t       pol_seg;
    seg_t       blank_seg;
    seg_t       seg_q;

    assign code = {C1, C2, C3, C4, C5};

    display_seg_lut u_lut (
        .code (code),
        .seg  (lut_seg)
    );

    // Polarity is applied ahead of the register so latency stays one cycle
`ifdef DISPLAY_ACTIVE_LOW_EN
    assign pol_seg   = ~lut_seg;
    assign blank_seg = ~SEG_BLANK;
`else
    assign pol_seg   = lut_seg;
    assign blank_seg = SEG_BLANK;
`endif

    // Output register: reset blanks the display, otherwise capture the glyph
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= blank_seg;
        end else begin
            seg_q <= pol_seg;
        end
    end

    assign {A, B, C, D, E, F, G} = seg_q;

endmodule : display
`default_nettype wire

// File: tb/tb_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display
//  Brief    : Self-checking bench for the display decoder. Directed steps
//             followed by random codes with occasional resets, compared
//             against a glyph table written from the character list.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_display;

    logic clk = 1'b0;
    logic rst;
    logic C1, C2, C3, C4, C5;
    logic A, B, C, D, E, F, G;

    int checks = 0;
    int fails  = 0;

    logic [6:0] glyph [32];

`ifdef DISPLAY_ACTIVE_LOW_EN
    localparam logic [6:0] POL_MASK = 7'b1111111;
`else
    localparam logic [6:0] POL_MASK = 7'b0000000;
`endif

    display dut (
        .clk (clk), .rst (rst),
        .C1 (C1), .C2 (C2), .C3 (C3), .C4 (C4), .C5 (C5),
        .A (A), .B (B), .C (C), .D (D), .E (E), .F (F), .G (G)
    );

    always #5 clk = ~clk;

    // Pin-level expectation: blank on reset, else the glyph, then polarity
    function automatic logic [6:0] model(input logic [4:0] code, input logic r);
        logic [6:0] lit;
        lit = r ? 7'b0000000 : glyph[code];
        return lit ^ POL_MASK;
    endfunction

    task automatic check(input string tag, input logic [6:0] expected);
        logic [6:0] observed;
        observed = {A, B, C, D, E, F, G};
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [4:0] code, input logic r);
        {C1, C2, C3, C4, C5} = code;
        rst = r;
    endtask

    // Apply inputs, take one edge, sample 1 time unit later and compare
    task automatic step(input string tag, input logic [4:0] code, input logic r);
        drive(code, r);
        @(posedge clk);
        #1;
        check(tag, model(code, r));
    endtask

    initial begin
        logic [4:0] rc;
        logic       rr;

        // ABCDEFG for codes 0..31, transcribed from the glyph list
        glyph = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                  7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                  7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
                  7'b0000001, 7'b0110111, 7'b0001110, 7'b1100111,
                  7'b0111110, 7'b0010101, 7'b0011101, 7'b0000101,
                  7'b0111011, 7'b0111000, 7'b0001111, 7'b0011100,
                  7'b0001101, 7'b0001000, 7'b1000000, 7'b0000000};

        // Reset held for two edges with all code bits high
        step("reset_edge1", 5'b11111, 1'b1);
        step("reset_edge2", 5'b11111, 1'b1);

        // Latency: output holds blank until the edge after release
        drive(5'b10111, 1'b0);
        #3;
        check("latency_hold", 7'b0000000 ^ POL_MASK);
        @(posedge clk);
        #1;
        check("latency_r", 7'b0000101 ^ POL_MASK);

        // Back-to-back codes, each one cycle later
        step("seq_t", 5'b11010, 1'b0);
        step("seq_9", 5'b01001, 1'b0);
        step("seq_2", 5'b00010, 1'b0);
        step("seq_0", 5'b00000, 1'b0);

        // Exhaustive sweep of all 32 codes
        for (int i = 0; i < 32; i++) begin
            step($sformatf("sweep_%0d", i), 5'(i), 1'b0);
        end

        // Reset mid-stream while code 8 is applied
        step("midrst_blank", 5'd8, 1'b1);
        step("midrst_eight", 5'd8, 1'b0);

        // Glitch: C3 toggled twice between edges, only edge value counts
        drive(5'd4, 1'b0);
        #2 C3 = 1'b0;
        #2 C3 = 1'b1;
        #2;
        check("glitch_hold", 7'b1111111 ^ POL_MASK);
        @(posedge clk);
        #1;
        check("glitch_4", 7'b0110011 ^ POL_MASK);
        drive(5'd0, 1'b0);
        #2 C3 = 1'b1;
        #2 C3 = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_0", 7'b1111110 ^ POL_MASK);

        // Random codes with occasional reset pulses
        for (int n = 0; n < 60; n++) begin
            rc = 5'($urandom_range(0, 31));
            rr = ($urandom_range(0, 9) == 0);
            step($sformatf("rand_%0d", n), rc, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_display
`default_nettype wire

// File: doc/display.md
DISPLAY -- requirements
Module: display

Interface
REQ-001 The module SHALL have exactly one clock; reset SHALL be synchronous and active-high.
REQ-002 The port `clk` SHALL be an input, 1 bit wide, and SHALL be the rising-edge clock for all state.
REQ-003 The port `rst` SHALL be an input, 1 bit wide, with synchronous active-high reset.
REQ-004 The ports `C1`, `C2`, `C3`, `C4`, `C5` SHALL each be 1-bit inputs forming the 5-bit code: `C1` is the MSB (weight 16) and `C5` is the LSB (weight 1).
REQ-005 The ports `A`, `B`, `C`, `D`, `E`, `F`, `G` SHALL each be 1-bit outputs driving the seven-segment lines, standard lettering (`A` top, clockwise, `G` middle).
REQ-006 The module SHALL have no parameters; the port order SHALL be `clk`, `rst`, `C1`..`C5`, `A`..`G`.

Function
REQ-007 Each rising edge of `clk` with `rst`=0 SHALL register the decoded pattern of the current code into `A`..`G`, giving a latency of 1 cycle.
REQ-008 Outputs SHALL come straight from flops, with no combinational path from the inputs to the outputs.
REQ-009 Segment polarity SHALL be active-high by default (1 = segment lit).
REQ-010 Codes 0-15 SHALL display hex digits, with patterns given as ABCDEFG:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001
- 4=0110011, 5=1011011, 6=1011111, 7=1110000
- 8=1111111, 9=1111011, A=1110111, b=0011111
- C=1001110, d=0111101, E=1001111, F=1000111
REQ-011 Codes 16-31 SHALL display symbols, with patterns given as ABCDEFG:
- 16 '-'=0000001, 17 H=0110111, 18 L=0001110, 19 P=1100111
- 20 U=0111110, 21 n=0010101, 22 o=0011101, 23 r=0000101
- 24 y=0111011, 25 J=0111000, 26 t=0001111, 27 u=0011100
- 28 c=0001101, 29 '_'=0001000, 30 overbar=1000000, 31 blank=0000000
REQ-012 The decode SHALL be total: all 32 codes are defined and no X SHALL propagate for known inputs.
REQ-013 An input change between edges SHALL have no effect until the next rising edge; only the value present at the edge is used.
REQ-014 Back-to-back code changes on consecutive cycles SHALL each appear exactly one cycle later, with none dropped.

Reset
REQ-015 With `rst`=1 at a rising edge, `A`..`G` SHALL become the blank pattern (all segments off) regardless of `C1`..`C5`.
REQ-016 Reset asserted mid-operation SHALL override decoding on that edge.
REQ-017 The first edge after `rst` falls SHALL load the decode of the code present at that edge.
REQ-018 The power-up value before the first reset is unspecified.

Configuration
REQ-019 The macro `DISPLAY_ACTIVE_LOW_EN` SHALL select segment polarity.
REQ-020 When `DISPLAY_ACTIVE_LOW_EN` is defined, all seven outputs SHALL be inverted for a common-anode display (0 = lit), and the reset/blank value SHALL be 1111111.
REQ-021 When `DISPLAY_ACTIVE_LOW_EN` is undefined, outputs SHALL be active-high as in REQ-009, and the reset/blank value SHALL be 0000000.
REQ-022 Polarity SHALL be applied after the lookup and before the output register, so latency stays at 1 cycle.

Structure
REQ-023 The package `display_pkg` SHALL hold:
- the 7-bit segment-pattern typedef;
- named constants for all 32 patterns;
- the constant `SEG_BLANK`.
REQ-024 The combinational code-to-pattern lookup SHALL be a single sub-module, `display_seg_lut` (5-bit in, 7-bit out, active-high).
REQ-025 The top level SHALL contain only the polarity stage and the output register.

Verification
REQ-026 Reset: hold `rst`=1 with code 11111 for 2 edges -> `A`..`G`=0000000 (1111111 with `DISPLAY_ACTIVE_LOW_EN`).
REQ-027 Latency: release reset and apply code 10111 (23) -> the next edge gives 0000101 ('r'); outputs hold their previous value until that edge.
REQ-028 Sequence: 11010, 01001, 00010, 00000 on consecutive edges -> 0001111 ('t'), 1111011 ('9'), 1101101 ('2'), 1111110 ('0'), each 1 cycle delayed.
REQ-029 Exhaustive sweep of codes 0-31 -> every output matches REQ-010/REQ-011 exactly, with no X.
REQ-030 Reset mid-stream: assert `rst` for one edge while code=8 -> that edge gives blank, and the following edge with `rst`=0 gives 1111111.
REQ-031 Glitch: toggle `C3` twice between edges -> only the value at the edge is reflected.
